// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: in-order instruction fetch with a small response FIFO.
// Keeps the PC, issues word-aligned memory requests under a credit limit so
// every returned word has a buffer slot, and presents {instr, pc} to decode.
// A redirect flushes the buffer and marks in-flight responses for discard.
// Optional feature macro FETCH_PERF_EN adds the perf_bubble_cnt output.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_bubble_cnt,
`endif
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = AW + 3;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [NW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_aq_wr;
  logic [AW-1:0] r_aq_rd;
  logic [31:0]   r_aq_mem     [FIFO_DEPTH];
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];

  logic          w_accept;
  logic          w_deq;
  logic          w_pop;
  logic          w_push;
  logic          w_drop_rsp;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_need;
  logic          w_unused_pc_bits;

  assign w_accept   = imem_req_valid & imem_req_ready;
  assign w_deq      = dec_valid & dec_ready;
  assign w_pop      = w_deq & ~redirect_valid;
  assign w_drop_rsp = imem_rsp_valid & (r_drop != '0);
  assign w_push     = imem_rsp_valid & (r_drop == '0) & ~redirect_valid;
  assign w_out_next = r_out + CW'(w_accept) - CW'(imem_rsp_valid);

  // Slots already promised: live (non-discarded) requests plus buffered words,
  // minus the word decode takes this cycle. Discarded responses need no slot,
  // which lets fetch restart the cycle right after a redirect.
  assign w_need = (r_out - r_drop) + CW'(r_count) - CW'(w_deq);

  assign imem_req_valid   = rst & ~redirect_valid & (w_need < CW'(FIFO_DEPTH));
  assign imem_req_addr    = r_pc;
  assign dec_valid        = (r_count != '0);
  assign dec_instr        = r_fifo_instr[r_rd_ptr];
  assign dec_pc           = r_fifo_pc[r_rd_ptr];
  assign w_unused_pc_bits = &{1'b0, redirect_pc[1:0]};

  // PC, request/discard counters and buffer pointers; redirect overrides all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_aq_wr  <= '0;
      r_aq_rd  <= '0;
    end else begin
      r_out <= w_out_next;
      if (redirect_valid) begin
        r_pc     <= {redirect_pc[31:2], 2'b00};
        r_drop   <= w_out_next;
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_aq_wr  <= '0;
        r_aq_rd  <= '0;
      end else begin
        if (w_accept) begin
          r_pc    <= r_pc + 32'd4;
          r_aq_wr <= r_aq_wr + AW'(1);
        end
        if (w_drop_rsp) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_push) begin
          r_aq_rd  <= r_aq_rd + AW'(1);
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + NW'(w_push) - NW'(w_pop);
      end
    end
  end

  // Request-address queue and instruction buffer storage, cleared on reset so
  // the decode outputs read zero until the first word lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_aq_mem[i]     <= '0;
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else begin
      if (w_accept && !redirect_valid) begin
        r_aq_mem[r_aq_wr] <= r_pc;
      end
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
        r_fifo_pc[r_wr_ptr]    <= r_aq_mem[r_aq_rd];
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_bubble_cnt;

  // Saturating count of cycles where decode was ready but had nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (dec_ready && !dec_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed bench for instr_fetch_stage with an in-order
// 1-cycle memory model and a stream-level decode model (consecutive PCs from
// the last restart point). Build with FETCH_PERF_EN to also cover the counter.
module tb_instr_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt;
`endif

  instr_fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_EN
    .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        done = 1'b0;
  logic        memStall = 1'b0;
  int          t6Start = 0;

  logic [31:0] memq[$];
  int          rspIdx = 0;

  logic [31:0] expReqPc;
  logic [31:0] expDecPc;
  logic [31:0] expBubble;
  int          live;
  int          maxLive;
  logic        prevRestart;
  logic        acc;
  logic        seenAcc;
  logic        wantRedirAcc;
  int          firstAccCyc;
  logic [31:0] firstAccAddr;
  int          firstDvCyc;
  logic [31:0] decPcLog[$];
  int          decCycLog[$];
  int          redirIdx[$];
  int          pendAtRedir[$];
  logic [31:0] redirAccAddr[$];
  logic [31:0] perfLog[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] logPc(input int idx);
    if (idx >= 0 && idx < decPcLog.size()) return decPcLog[idx];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic finalChecks();
    logic [31:0] t2Pcs[8];
    logic [31:0] t5Pcs[3];
    t2Pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C};
    t5Pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    checkOutput("t1_first_req_addr", firstAccAddr, 32'h100);
    checkOutput("t1_first_req_cycle", 32'(firstAccCyc), 32'd0);
    checkOutput("t1_first_dec_valid_cycle", 32'(firstDvCyc), 32'd2);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2_dec_pc", logPc(i), t2Pcs[i]);
      checkOutput("t2_dec_cycle", (i < decCycLog.size()) ? 32'(decCycLog[i]) : 32'hBAD0_BAD0, 32'(2 + i));
    end
    checkOutput("t3_max_live_fetches", 32'(maxLive), 32'(DEPTH));
    checkOutput("t4_outstanding_at_redirect", (pendAtRedir.size() > 0) ? 32'(pendAtRedir[0]) : 32'hBAD0_BAD0, 32'd2);
    checkOutput("t4_first_req_after_redirect", (redirAccAddr.size() > 0) ? redirAccAddr[0] : 32'hBAD0_BAD0, 32'h200);
    checkOutput("t4_first_dec_pc_after_redirect", (redirIdx.size() > 0) ? logPc(redirIdx[0]) : 32'hBAD0_BAD0, 32'h200);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t5_wrap_dec_pc", (redirIdx.size() > 1) ? logPc(redirIdx[1] + k) : 32'hBAD0_BAD0, t5Pcs[k]);
    end
`ifdef FETCH_PERF_EN
    checkOutput("t6_bubble_delta",
                (t6Start + 6 < perfLog.size()) ? (perfLog[t6Start + 6] - perfLog[t6Start]) : 32'hBAD0_BAD0,
                32'd3);
`endif
  endtask

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order memory: answers one accepted request per cycle, one cycle after
  // acceptance at the earliest, unless the stimulus is stalling it.
  always begin
    @(posedge clk);
    #2;
    if (rst && !memStall && rspIdx < memq.size()) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(memq[rspIdx]);
      rspIdx++;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Compare process: checks every cycle against the stream-level model and
  // records the events the directed expectations are pinned on.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
      checkOutput("reset_dec_valid", {31'b0, dec_valid}, 32'd0);
      checkOutput("reset_dec_instr", dec_instr, 32'd0);
      checkOutput("reset_dec_pc", dec_pc, 32'd0);
`ifdef FETCH_PERF_EN
      checkOutput("reset_perf", perf_bubble_cnt, 32'd0);
`endif
      cyc = 0;
      expReqPc = RST_PC;
      expDecPc = RST_PC;
      expBubble = 32'd0;
      live = 0;
      maxLive = 0;
      prevRestart = 1'b1;
      seenAcc = 1'b0;
      wantRedirAcc = 1'b0;
      firstAccCyc = -1;
      firstAccAddr = 32'hBAD0_BAD0;
      firstDvCyc = -1;
    end else begin
`ifdef FETCH_PERF_EN
      checkOutput("perf_bubble_cnt", perf_bubble_cnt, expBubble);
      perfLog.push_back(perf_bubble_cnt);
      if (dec_ready && !dec_valid && expBubble != 32'hFFFF_FFFF) expBubble = expBubble + 32'd1;
`endif
      if (redirect_valid) checkOutput("req_valid_during_redirect", {31'b0, imem_req_valid}, 32'd0);
      else if (prevRestart) checkOutput("req_valid_after_restart", {31'b0, imem_req_valid}, 32'd1);
      if (prevRestart) checkOutput("dec_valid_after_restart", {31'b0, dec_valid}, 32'd0);
      if (imem_req_valid) checkOutput("req_addr", imem_req_addr, expReqPc);
      if (dec_valid && firstDvCyc < 0) firstDvCyc = cyc;

      acc = imem_req_valid & imem_req_ready;
      if (acc) begin
        memq.push_back(imem_req_addr);
        if (!seenAcc) begin
          seenAcc = 1'b1;
          firstAccCyc = cyc;
          firstAccAddr = imem_req_addr;
        end
        if (wantRedirAcc) begin
          redirAccAddr.push_back(imem_req_addr);
          wantRedirAcc = 1'b0;
        end
      end

      if (redirect_valid) begin
        pendAtRedir.push_back(memq.size() - rspIdx);
        redirIdx.push_back(decPcLog.size());
        wantRedirAcc = 1'b1;
        expReqPc = {redirect_pc[31:2], 2'b00};
        expDecPc = {redirect_pc[31:2], 2'b00};
        live = 0;
        prevRestart = 1'b1;
      end else begin
        prevRestart = 1'b0;
        if (acc) begin
          expReqPc = expReqPc + 32'd4;
          live++;
        end
        if (dec_valid && dec_ready) begin
          checkOutput("dec_pc", dec_pc, expDecPc);
          checkOutput("dec_instr", dec_instr, memWord(expDecPc));
          decPcLog.push_back(dec_pc);
          decCycLog.push_back(cyc);
          expDecPc = expDecPc + 32'd4;
          live--;
        end
        if (live > maxLive) maxLive = live;
        checkOutput("fetch_credit_bound", {31'b0, (live <= DEPTH)}, 32'd1);
      end
      cyc++;

      if (done) begin
        finalChecks();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic applyStimulus(input logic memRdy, input logic decRdy, input logic redir,
                               input logic [31:0] rpc, input logic stall, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      imem_req_ready = memRdy;
      dec_ready      = decRdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      memStall       = stall;
    end
  endtask

  // Directed scenario sequence: reset, streaming, backpressure, redirects, stall.
  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    $display("[TB] reset released, streaming from 0x%08h", RST_PC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9);
    $display("[TB] decode backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 6);
    $display("[TB] redirect with requests outstanding");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 10);
    $display("[TB] redirect across the address wrap");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 10);
    $display("[TB] three-cycle memory stall");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1);
    t6Start = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9);
    done = 1'b1;
    repeat (20) @(posedge clk);
    $display("[TB] FAIL end_of_test actual=not_reached expected=summary");
    $fatal(1, "[TB] compare process did not finish");
  end

endmodule
